// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: byte width and sequencer state encoding.
package uart_tx_fifo_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy count and a registered pop output.
// A write while full is dropped even if a pop happens in the same cycle.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = BYTE_W
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // NOTE: the storage array has no reset; stale contents are unreachable because
  // count and the pointers are reset, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: every sequential assignment is non-blocking so all flops update from
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk1) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and send sequencer in front of the UART transmitter: queues host
// bytes and hands them over one at a time, waiting for tx_done between bytes.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int SEND_HOLD = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  input  logic              tx_done,
  output logic [7:0]        parallel_datain,
  output logic              send,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow
);

  localparam int              HOLD_W    = (SEND_HOLD > 1) ? $clog2(SEND_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SEND_HOLD - 1);

  tx_state_e         state;
  tx_state_e         state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic              tx_done_q;
  logic              done_rise;
  logic              pop;

  // parallel_datain is the FIFO's registered pop output, so it only moves on LOAD.
  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (BYTE_W)
  ) u_fifo (
    .clk1    (clk1),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (parallel_datain),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign done_rise = tx_done & ~tx_done_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      tx_done_q <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      tx_done_q <= tx_done;
      if (state == LOAD)      hold_cnt <= '0;
      else if (state == SEND) hold_cnt <= hold_cnt + HOLD_W'(1);
      // A dropped write wins over a simultaneous clear.
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_ovf)  overflow <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    send       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_next = LOAD;
      end
      LOAD: begin
        pop        = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        send = 1'b1;
        if (hold_cnt == HOLD_LAST) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized traffic,
// with a byte-order scoreboard checked by an independent send monitor.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int SEND_HOLD = 4;

  logic            clk1 = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            clr_ovf = 1'b0;
  logic            tx_done;
  logic [7:0]      parallel_datain;
  logic            send;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            busy;
  logic            overflow;

  logic auto_done = 1'b0;
  logic auto_pulse = 1'b0;
  logic man_done = 1'b0;

  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int sends_seen = 0;

  assign tx_done = auto_done ? auto_pulse : man_done;

  always #5 clk1 = ~clk1;

  uart_tx_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .SEND_HOLD (SEND_HOLD)
  ) dut (
    .clk1            (clk1),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .clr_ovf         (clr_ovf),
    .tx_done         (tx_done),
    .parallel_datain (parallel_datain),
    .send            (send),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .busy            (busy),
    .overflow        (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Drives one write cycle; accept says whether the byte should come out later.
  task automatic write_byte(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || !empty) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_send(input logic level, input int budget, input string name);
    int n = 0;
    while (send !== level && n < budget) begin
      tick();
      n++;
    end
    check({name, "_send_timeout"}, 32'(n < budget), 32'd1);
  endtask

  // Transmitter stand-in: answers each completed send with a tx_done pulse.
  initial forever begin
    @(negedge send);
    if (auto_done) begin
      repeat ($urandom_range(0, 3)) @(posedge clk1);
      #1 auto_pulse = 1'b1;
      @(posedge clk1);
      #1 auto_pulse = 1'b0;
    end
  end

  // Monitor: each send request must carry the next expected byte, last exactly
  // SEND_HOLD cycles, and keep the byte stable; occupancy never exceeds DEPTH.
  initial begin
    logic       prev_send = 1'b0;
    int         run = 0;
    logic [7:0] held = 8'h00;
    forever begin
      @(negedge clk1);
      if (rst) begin
        prev_send = 1'b0;
        run = 0;
      end else begin
        check("count_le_depth", 32'(int'(count) <= DEPTH), 32'd1);
        if (send && !prev_send) begin
          sends_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_send", 32'd1, 32'd0);
          end else begin
            check("tx_byte", 32'(parallel_datain), 32'(exp_q.pop_front()));
          end
          held = parallel_datain;
          run = 1;
        end else if (send) begin
          run++;
          check("byte_stable", 32'(parallel_datain), 32'(held));
        end else if (prev_send) begin
          check("send_width", 32'(run), 32'(SEND_HOLD));
        end
        prev_send = send;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat;
    int base;
    int n_written;
    int guard;

    // Reset state
    repeat (3) @(posedge clk1);
    #1 rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_send", 32'(send), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(parallel_datain), 32'h00);

    // Single byte: send high for SEND_HOLD cycles starting 3 cycles after the write
    tick();
    write_byte(8'hA5, 1'b1);
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk1);
      if (i == 0) check("single_empty_n1", 32'(empty), 32'd0);
      pat = {pat[5:0], send};
    end
    check("single_send_pattern", 32'(pat), 32'(7'b0011110));
    check("single_data", 32'(parallel_datain), 32'hA5);
    check("single_busy_wait", 32'(busy), 32'd1);
    @(posedge clk1);
    #1 man_done = 1'b1;
    tick();
    man_done = 1'b0;
    @(negedge clk1);
    check("single_busy_done", 32'(busy), 32'd0);
    check("single_empty_done", 32'(empty), 32'd1);
    tick();

    // Burst and order
    auto_done = 1'b1;
    base = sends_seen;
    for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
    wait_drained(400, "burst");
    check("burst_count", 32'(count), 32'd0);
    check("burst_sends", 32'(sends_seen - base), 32'd5);
    tick();
    auto_done = 1'b0;

    // Full and overflow: first byte leaves via LOAD, so 17 writes fill the FIFO
    for (int i = 0; i < 17; i++) write_byte(8'h40 + 8'(i), 1'b1);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_no_ovf", 32'(overflow), 32'd0);
    write_byte(8'hEE, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    clr_ovf = 1'b1;
    write_byte(8'hEF, 1'b0);
    clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr2", 32'(overflow), 32'd0);
    // Write while full in the same cycle as the LOAD pop: still dropped
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    wr_en = 1'b1;
    wr_data = 8'hD1;
    tick();
    check("pop_drop_ovf", 32'(overflow), 32'd1);
    check("pop_drop_count", 32'(count), 32'd15);
    check("pop_drop_notfull", 32'(full), 32'd0);
    wr_data = 8'hD2;
    exp_q.push_back(8'hD2);
    tick();
    wr_en = 1'b0;
    check("refill_count", 32'(count), 32'd16);
    check("refill_full", 32'(full), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    auto_done = 1'b1;
    wait_drained(2000, "full");
    check("full_drain_count", 32'(count), 32'd0);
    tick();
    auto_done = 1'b0;

    // Spurious and level done: only the rise seen in WAIT_DONE completes the byte
    base = sends_seen;
    man_done = 1'b1;
    write_byte(8'h77, 1'b1);
    wait_send(1'b1, 20, "level_hi");
    wait_send(1'b0, 20, "level_lo");
    repeat (3) tick();
    check("level_held_ignored", 32'(busy), 32'd1);
    man_done = 1'b0;
    repeat (2) tick();
    check("level_low_wait", 32'(busy), 32'd1);
    man_done = 1'b1;
    tick();
    check("level_second_rise", 32'(busy), 32'd0);
    man_done = 1'b0;
    tick();
    check("level_one_send", 32'(sends_seen - base), 32'd1);

    // Reset mid-send with 3 bytes queued
    for (int i = 0; i < 4; i++) write_byte(8'hC1 + 8'(i), 1'b1);
    wait_send(1'b1, 20, "rst_mid");
    check("rst_mid_queued", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rst_mid_send", 32'(send), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_empty", 32'(empty), 32'd1);
    check("rst_mid_data", 32'(parallel_datain), 32'h00);
    check("rst_mid_busy", 32'(busy), 32'd0);
    auto_done = 1'b1;
    base = sends_seen;
    write_byte(8'h3C, 1'b1);
    wait_drained(200, "post_rst");
    check("post_rst_sends", 32'(sends_seen - base), 32'd1);

    // Randomized traffic across pointer wrap; never outrun the buffer
    base = sends_seen;
    n_written = 0;
    guard = 0;
    while (n_written < 40 && guard < 5000) begin
      if (exp_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
        write_byte(8'($urandom), 1'b1);
        n_written++;
      end else begin
        tick();
      end
      guard++;
    end
    check("rand_written", 32'(n_written), 32'd40);
    wait_drained(3000, "rand");
    check("rand_sends", 32'(sends_seen - base), 32'd40);
    check("rand_count", 32'(count), 32'd0);
    check("rand_no_ovf", 32'(overflow), 32'd0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
